cla_slice_sequencer: RTL and testbench

Multi-cycle wide adder built on one shared SLICE-bit carry-lookahead slice, made from bitwise generate/propagate cells and a lookahead carry network. It processes WIDTH/SLICE slices from least-significant to most-significant, one slice per clock, and chains the carry through a register. It also returns the block-level group generate/propagate so the result can feed a higher-level lookahead stage. Operands enter and results leave over valid/ready handshakes.

---
 rtl/cla_slice_sequencer.sv | 147 ++++++++++++++
 tb/tb_cla_slice_sequencer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/cla_slice_sequencer.sv
// Multi-cycle WIDTH-bit adder that reuses one SLICE-bit carry-lookahead slice,
// walking slices LSB to MSB and returning block-level group generate/propagate.
module cla_slice_sequencer #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             group_g,
    output logic             group_p,
    output logic             busy
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             g_acc;
    logic             p_acc;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             group_g_q;
    logic             group_p_q;

    logic [SLICE-1:0] sa, sb, g, p;
    logic [SLICE-1:0] pg, pp;
    logic [SLICE:0]   c;
    logic [SLICE-1:0] slice_sum;
    logic             gs, ps;
    logic             accept;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;

    assign sum     = sum_q;
    assign cout    = cout_q;
    assign group_g = group_g_q;
    assign group_p = group_p_q;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        sa = '0;
        sb = '0;
        for (int k = 0; k < N; k++) begin
            if (cnt_q == CW'(k)) begin
                sa = a_q[k*SLICE +: SLICE];
                sb = b_q[k*SLICE +: SLICE];
            end
        end
        g = sa & sb;
        p = sa ^ sb;

        // Prefix group terms over bits [j:0]; every carry is then one level from carry_q.
        pg[0] = g[0];
        pp[0] = p[0];
        for (int j = 1; j < SLICE; j++) begin
            pg[j] = g[j] | (p[j] & pg[j-1]);
            pp[j] = p[j] & pp[j-1];
        end

        c[0] = carry_q;
        for (int j = 0; j < SLICE; j++) begin
            c[j+1] = pg[j] | (pp[j] & carry_q);
        end

        slice_sum = p ^ c[SLICE-1:0];
        gs        = pg[SLICE-1];
        ps        = pp[SLICE-1];
    end

    // NOTE: operand registers are pure datapath loaded on accept, so they carry no reset.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            a_q <= a;
            b_q <= b;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            g_acc     <= 1'b0;
            p_acc     <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            group_g_q <= 1'b0;
            group_p_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        carry_q <= cin;
                        cnt_q   <= '0;
                        g_acc   <= 1'b0;
                        p_acc   <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    for (int k = 0; k < N; k++) begin
                        if (cnt_q == CW'(k)) sum_q[k*SLICE +: SLICE] <= slice_sum;
                    end
                    carry_q <= c[SLICE];
                    g_acc   <= gs | (ps & g_acc);
                    p_acc   <= ps & p_acc;
                    if (cnt_q == LAST) begin
                        // Published results only change here, so they hold through IDLE.
                        cout_q    <= c[SLICE];
                        group_g_q <= gs | (ps & g_acc);
                        group_p_q <= ps & p_acc;
                        state     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_slice_sequencer.sv
// Directed and random checks of cla_slice_sequencer at WIDTH=16, SLICE=4.
module tb_cla_slice_sequencer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         group_g;
    logic         group_p;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    int n_out    = 0;

    cla_slice_sequencer #(.WIDTH(W), .SLICE(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .group_g   (group_g),
        .group_p   (group_p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) n_acc++;
            if (out_valid && out_ready) n_out++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction; poke drives foreign operands during RUN and DONE to show they are ignored.
    task automatic do_add(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                          input int stall, input bit poke,
                          input logic [W-1:0] es, input logic ec, input logic eg, input logic ep);
        int lat;
        check("in_ready_idle", in_ready, 1);
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        if (poke) begin
            a = ~ta; b = ta; cin = ~tc; in_valid = 1'b1;
        end
        lat = 0;
        while (!out_valid && lat < 20) begin
            check("busy_run", busy, 1);
            tick();
            lat++;
        end
        check("latency", lat, 4);
        check("sum", sum, es);
        check("cout", cout, ec);
        check("group_g", group_g, eg);
        check("group_p", group_p, ep);
        check("cout_identity", cout, eg | (ep & tc));
        repeat (stall) begin
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_sum", sum, es);
            check("hold_cout", {cout, group_g, group_p}, {ec, eg, ep});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("valid_drop", out_valid, 0);
        check("sum_after", sum, es);
    endtask

    task automatic rand_add(input int stall);
        logic [W-1:0] ta, tb_, s;
        logic         tc, co, gg, gp;
        ta  = W'($urandom);
        tb_ = W'($urandom);
        tc  = 1'($urandom);
        {co, s} = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc};
        gg = 1'(({1'b0, ta} + {1'b0, tb_}) >> W);
        gp = &(ta ^ tb_);
        do_add(ta, tb_, tc, stall, 1'b0, s, co, gg, gp);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 0);
        check("rst_flags", {cout, group_g, group_p}, 3'b000);

        do_add(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        do_add(16'h1234, 16'h4321, 1'b1, 0, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0);
        do_add(16'hAAAA, 16'h5555, 1'b1, 0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        do_add(16'hAAAA, 16'h5555, 1'b0, 0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1);
        do_add(16'h1234, 16'h4321, 1'b1, 3, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b0);

        // Reset while slice 2 is in flight drops the transaction.
        a = 16'h1234; b = 16'h4321; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_sum", sum, 0);
        check("midrst_cout", cout, 0);
        do_add(16'h0001, 16'h0001, 1'b0, 0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            rand_add(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        check("no_loss_dup", n_out, n_acc - 1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
